// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction, one response out.
// Optional watchdog is compiled in when AXIML_TIMEOUT_EN is defined.
module axi_lite_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  i_axi_clk,
   input  logic                  i_axi_rst,
   input  logic                  i_cmd_valid,
   output logic                  o_cmd_ready,
   input  logic                  i_cmd_wr,
   input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
   input  logic [31:0]           i_cmd_data,
   input  logic [3:0]            i_cmd_strb,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [31:0]           o_rsp_data,
   output logic [1:0]            o_rsp_resp,
   output logic                  o_awvalid,
   output logic [ADDR_WIDTH-1:0] o_awaddr,
   input  logic                  i_awready,
   output logic                  o_wvalid,
   input  logic                  i_wready,
   output logic [31:0]           o_wdata,
   output logic [3:0]            o_wstrb,
   input  logic                  i_bvalid,
   output logic                  o_bready,
   input  logic [1:0]            i_bresp,
   output logic                  o_arvalid,
   input  logic                  i_arready,
   output logic [ADDR_WIDTH-1:0] o_araddr,
   input  logic                  i_rvalid,
   output logic                  o_rready,
   input  logic [1:0]            i_rresp,
   input  logic [31:0]           i_rdata,
   output logic                  o_timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_REQ,
      S_WR_RESP,
      S_RD_ADDR,
      S_RD_DATA,
      S_RSP
   } state_t;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            strb_q, strb_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  arvalid_q, arvalid_d;
   logic                  bready_q, bready_d;
   logic                  rready_q, rready_d;
   logic [31:0]           rsp_data_q, rsp_data_d;
   logic [1:0]            rsp_resp_q, rsp_resp_d;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

   assign aw_hs = awvalid_q & i_awready;
   assign w_hs  = wvalid_q & i_wready;
   assign b_hs  = bready_q & i_bvalid;
   assign ar_hs = arvalid_q & i_arready;
   assign r_hs  = rready_q & i_rvalid;

`ifdef AXIML_TIMEOUT_EN
   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
   logic             busy, any_hs, expire;

   // Counter is zero in IDLE/RSP, so it starts from 0 on entry to WR_REQ/RD_ADDR.
   // A handshake in the expiry cycle defers expiry; >= keeps it armed afterwards.
   always_comb begin
      busy      = (state_q != S_IDLE) && (state_q != S_RSP);
      any_hs    = aw_hs | w_hs | b_hs | ar_hs | r_hs;
      expire    = busy && (cnt_q >= CNT_LAST) && !any_hs;
      cnt_d     = '0;
      if (busy) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end
      timeout_d = expire;
   end

   always_ff @(posedge i_axi_clk) begin
      if (i_axi_rst) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_timeout = timeout_q;
`else
   assign o_timeout = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      strb_d     = strb_q;
      awvalid_d  = awvalid_q;
      wvalid_d   = wvalid_q;
      arvalid_d  = arvalid_q;
      bready_d   = bready_q;
      rready_d   = rready_q;
      rsp_data_d = rsp_data_q;
      rsp_resp_d = rsp_resp_q;

      case (state_q)
         S_IDLE: begin
            if (i_cmd_valid) begin
               addr_d  = i_cmd_addr;
               wdata_d = i_cmd_data;
               strb_d  = i_cmd_strb;
               if (i_cmd_wr) begin
                  state_d   = S_WR_REQ;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = S_RD_ADDR;
                  arvalid_d = 1'b1;
               end
            end
         end
         S_WR_REQ: begin
            // AW and W retire independently; leave once neither is still pending.
            if (aw_hs) awvalid_d = 1'b0;
            if (w_hs)  wvalid_d  = 1'b0;
            if ((aw_hs || !awvalid_q) && (w_hs || !wvalid_q)) begin
               state_d  = S_WR_RESP;
               bready_d = 1'b1;
            end
         end
         S_WR_RESP: begin
            if (b_hs) begin
               rsp_resp_d = i_bresp;
               rsp_data_d = 32'h0;
               bready_d   = 1'b0;
               state_d    = S_RSP;
            end
         end
         S_RD_ADDR: begin
            if (ar_hs) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            if (r_hs) begin
               rsp_resp_d = i_rresp;
               rsp_data_d = i_rdata;
               rready_d   = 1'b0;
               state_d    = S_RSP;
            end
         end
         S_RSP: begin
            if (i_rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

`ifdef AXIML_TIMEOUT_EN
      if (expire) begin
         awvalid_d  = 1'b0;
         wvalid_d   = 1'b0;
         arvalid_d  = 1'b0;
         bready_d   = 1'b0;
         rready_d   = 1'b0;
         rsp_resp_d = 2'b11;
         rsp_data_d = 32'hDEADDEAD;
         state_d    = S_RSP;
      end
`endif
   end

   always_ff @(posedge i_axi_clk) begin
      if (i_axi_rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         strb_q     <= '0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         arvalid_q  <= 1'b0;
         bready_q   <= 1'b0;
         rready_q   <= 1'b0;
         rsp_data_q <= '0;
         rsp_resp_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         strb_q     <= strb_d;
         awvalid_q  <= awvalid_d;
         wvalid_q   <= wvalid_d;
         arvalid_q  <= arvalid_d;
         bready_q   <= bready_d;
         rready_q   <= rready_d;
         rsp_data_q <= rsp_data_d;
         rsp_resp_q <= rsp_resp_d;
      end
   end

   assign o_cmd_ready = (state_q == S_IDLE);
   assign o_rsp_valid = (state_q == S_RSP);
   assign o_rsp_data  = rsp_data_q;
   assign o_rsp_resp  = rsp_resp_q;
   assign o_awvalid   = awvalid_q;
   assign o_awaddr    = addr_q;
   assign o_wvalid    = wvalid_q;
   assign o_wdata     = wdata_q;
   assign o_wstrb     = strb_q;
   assign o_bready    = bready_q;
   assign o_arvalid   = arvalid_q;
   assign o_araddr    = addr_q;
   assign o_rready    = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: configurable-latency slave, protocol monitor,
// and a word-memory reference model that predicts response data, resp and latency.
module tb_axi_lite_master;
   localparam int AW     = 32;
   localparam int TO_CYC = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_cmd_valid, i_cmd_wr, i_rsp_ready;
   logic [AW-1:0] i_cmd_addr;
   logic [31:0]   i_cmd_data;
   logic [3:0]    i_cmd_strb;
   logic          o_cmd_ready, o_rsp_valid;
   logic [31:0]   o_rsp_data;
   logic [1:0]    o_rsp_resp;
   logic          o_awvalid, i_awready, o_wvalid, i_wready;
   logic [AW-1:0] o_awaddr, o_araddr;
   logic [31:0]   o_wdata, i_rdata;
   logic [3:0]    o_wstrb;
   logic          i_bvalid, o_bready, o_arvalid, i_arready, i_rvalid, o_rready;
   logic [1:0]    i_bresp, i_rresp;
   logic          o_timeout;

   always #5 clk = ~clk;

   axi_lite_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .i_axi_clk(clk), .i_axi_rst(rst),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_wr(i_cmd_wr),
      .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_cmd_strb(i_cmd_strb),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
      .o_rsp_data(o_rsp_data), .o_rsp_resp(o_rsp_resp),
      .o_awvalid(o_awvalid), .o_awaddr(o_awaddr), .i_awready(i_awready),
      .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
      .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
      .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
      .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rresp(i_rresp), .i_rdata(i_rdata),
      .o_timeout(o_timeout)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Address map: top nibble F -> SLVERR, E -> DECERR, otherwise OKAY.
   function automatic logic [1:0] addr_resp(input logic [31:0] a);
      case (a[31:28])
         4'hF:    return 2'b10;
         4'hE:    return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   logic [31:0] ref_mem [16];
   logic [31:0] slv_mem [16];

   // ---------------- slave ----------------
   int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
   logic        aw_got, w_got, b_done, ar_got, r_done;
   logic        b_drive, r_drive, b_pend, r_pend, spur;
   logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
   logic [3:0]  cap_wstrb;

   initial begin
      i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = 0;
      i_arready = 0; i_rvalid = 0; i_rresp = 0; i_rdata = 0;
      aw_got = 0; w_got = 0; b_done = 1; ar_got = 0; r_done = 1;
      b_drive = 0; r_drive = 0; b_pend = 0; r_pend = 0; spur = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            aw_got = 0; w_got = 0; b_done = 1; ar_got = 0; r_done = 1;
            b_drive = 0; r_drive = 0; b_pend = 0; r_pend = 0;
            i_awready = 0; i_wready = 0; i_arready = 0;
         end else begin
            // response channels first so they start a cycle after the request handshake
            if (b_pend) begin
               b_drive = 0; b_pend = 0;
            end else if (aw_got && w_got && !b_done) begin
               if (!b_drive && b_wait > 0) b_wait--;
               else begin
                  b_drive = 1;
                  i_bresp = addr_resp(cap_awaddr);
                  if (o_bready) begin
                     b_pend = 1; b_done = 1;
                     if (addr_resp(cap_awaddr) == 2'b00)
                        for (int b = 0; b < 4; b++)
                           if (cap_wstrb[b]) slv_mem[cap_awaddr[5:2]][8*b +: 8] = cap_wdata[8*b +: 8];
                  end
               end
            end
            if (r_pend) begin
               r_drive = 0; r_pend = 0;
            end else if (ar_got && !r_done) begin
               if (!r_drive && r_wait > 0) r_wait--;
               else begin
                  r_drive = 1;
                  i_rresp = addr_resp(cap_araddr);
                  i_rdata = slv_mem[cap_araddr[5:2]];
                  if (o_rready) begin r_pend = 1; r_done = 1; end
               end
            end
            i_awready = 0;
            if (o_awvalid && !aw_got) begin
               if (aw_wait > 0) aw_wait--;
               else begin i_awready = 1; aw_got = 1; cap_awaddr = o_awaddr; end
            end
            i_wready = 0;
            if (o_wvalid && !w_got) begin
               if (w_wait > 0) w_wait--;
               else begin i_wready = 1; w_got = 1; cap_wdata = o_wdata; cap_wstrb = o_wstrb; end
            end
            i_arready = 0;
            if (o_arvalid && !ar_got) begin
               if (ar_wait > 0) ar_wait--;
               else begin i_arready = 1; ar_got = 1; cap_araddr = o_araddr; end
            end
         end
         i_bvalid = b_drive | spur;
         i_rvalid = r_drive | spur;
      end
   end

   // ---------------- monitor ----------------
   int          m_aw_hs = 0, m_w_hs = 0, m_b_hs = 0, m_ar_hs = 0, m_r_hs = 0;
   int          m_aw_hi = 0, m_w_hi = 0, m_ar_hi = 0, m_to = 0, m_viol = 0;
   logic        p_aw = 0, p_w = 0, p_ar = 0;
   logic [31:0] p_awaddr, p_wdata, p_araddr;
   logic [3:0]  p_wstrb;

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            p_aw = 0; p_w = 0; p_ar = 0;
         end else begin
            if (o_awvalid) m_aw_hi++;
            if (o_wvalid)  m_w_hi++;
            if (o_arvalid) m_ar_hi++;
            if (o_awvalid && i_awready) m_aw_hs++;
            if (o_wvalid && i_wready)   m_w_hs++;
            if (o_arvalid && i_arready) m_ar_hs++;
            if (o_bready && i_bvalid)   m_b_hs++;
            if (o_rready && i_rvalid)   m_r_hs++;
            if (o_timeout) m_to++;
            if (!o_timeout) begin
               if (p_aw && (!o_awvalid || o_awaddr !== p_awaddr)) m_viol++;
               if (p_w && (!o_wvalid || o_wdata !== p_wdata || o_wstrb !== p_wstrb)) m_viol++;
               if (p_ar && (!o_arvalid || o_araddr !== p_araddr)) m_viol++;
            end
            p_aw = o_awvalid && !i_awready; p_awaddr = o_awaddr;
            p_w  = o_wvalid && !i_wready;   p_wdata = o_wdata; p_wstrb = o_wstrb;
            p_ar = o_arvalid && !i_arready; p_araddr = o_araddr;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // One full command/response exchange; waits are slave stall cycles per channel.
   task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int aw_w, input int w_w, input int b_w,
                         input int ar_w, input int r_w, input int hold, input logic exp_to);
      logic [31:0] exp_data, d0;
      logic [1:0]  exp_resp, r0;
      int          exp_lat, lat, busy_rdy, hold_err;
      int          s_aw, s_w, s_b, s_ar, s_r, s_awh, s_wh, s_arh, s_to, s_v;
      int          idx;
      idx = int'(addr[5:2]);
      if (exp_to) begin
         exp_resp = 2'b11; exp_data = 32'hDEADDEAD; exp_lat = TO_CYC + 1;
      end else if (wr) begin
         exp_resp = addr_resp(addr); exp_data = 32'h0;
         exp_lat  = 3 + ((aw_w > w_w) ? aw_w : w_w) + b_w;
         if (exp_resp == 2'b00)
            for (int b = 0; b < 4; b++)
               if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
      end else begin
         exp_resp = addr_resp(addr); exp_data = ref_mem[idx];
         exp_lat  = 3 + ar_w + r_w;
      end
      aw_wait = aw_w; w_wait = w_w; b_wait = b_w; ar_wait = ar_w; r_wait = r_w;
      aw_got = 0; w_got = 0; ar_got = 0; b_done = !wr; r_done = wr;
      s_aw = m_aw_hs; s_w = m_w_hs; s_b = m_b_hs; s_ar = m_ar_hs; s_r = m_r_hs;
      s_awh = m_aw_hi; s_wh = m_w_hi; s_arh = m_ar_hi; s_to = m_to; s_v = m_viol;

      check("cmd_ready_before", o_cmd_ready, 1);
      i_cmd_valid = 1; i_cmd_wr = wr; i_cmd_addr = addr; i_cmd_data = data; i_cmd_strb = strb;
      tick();
      i_cmd_valid = 0;
      lat = 1; busy_rdy = 0;
      while (!o_rsp_valid && lat < 400) begin
         if (o_cmd_ready) busy_rdy++;
         tick();
         lat++;
      end
      if (!o_rsp_valid) begin
         check("rsp_wait_bound", 0, 1);
         rst = 1; tick(); rst = 0;
         return;
      end
      if (o_cmd_ready) busy_rdy++;
      check("latency", lat, exp_lat);
      check("rsp_data", o_rsp_data, exp_data);
      check("rsp_resp", o_rsp_resp, exp_resp);
      d0 = o_rsp_data; r0 = o_rsp_resp; hold_err = 0;
      for (int i = 0; i < hold; i++) begin
         tick();
         if (!o_rsp_valid || o_rsp_data !== d0 || o_rsp_resp !== r0 || o_cmd_ready) hold_err++;
      end
      check("rsp_hold", hold_err, 0);
      check("busy_cmd_ready", busy_rdy, 0);
      i_rsp_ready = 1;
      tick();
      i_rsp_ready = 0;
      check("rsp_valid_after", o_rsp_valid, 0);
      check("cmd_ready_after", o_cmd_ready, 1);
      check("idle_valids", {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready}, 0);
      check("aw_hs", m_aw_hs - s_aw, wr ? 1 : 0);
      check("w_hs", m_w_hs - s_w, wr ? 1 : 0);
      check("b_hs", m_b_hs - s_b, wr ? 1 : 0);
      check("ar_hs", m_ar_hs - s_ar, (!wr && !exp_to) ? 1 : 0);
      check("r_hs", m_r_hs - s_r, (!wr && !exp_to) ? 1 : 0);
      check("awvalid_cycles", m_aw_hi - s_awh, wr ? aw_w + 1 : 0);
      check("wvalid_cycles", m_w_hi - s_wh, wr ? w_w + 1 : 0);
      check("arvalid_cycles", m_ar_hi - s_arh, wr ? 0 : (exp_to ? TO_CYC : ar_w + 1));
      check("timeout_pulses", m_to - s_to, exp_to ? 1 : 0);
      check("proto_viol", m_viol - s_v, 0);
   endtask

   initial begin
      int viol, rsp_seen;
      rst = 1; i_cmd_valid = 0; i_cmd_wr = 0; i_cmd_addr = 0; i_cmd_data = 0;
      i_cmd_strb = 0; i_rsp_ready = 0;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = 32'h1000_0000 + i;
         slv_mem[i] = 32'h1000_0000 + i;
      end
      repeat (3) tick();
      check("rst_cmd_ready", o_cmd_ready, 1);
      check("rst_valids", {o_rsp_valid, o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_timeout}, 0);
      check("rst_rsp", {o_rsp_data, o_rsp_resp}, 0);
      check("rst_addr_data", {o_awaddr, o_wdata, o_wstrb}, 0);
      check("rst_araddr", o_araddr, 0);
      rst = 0;
      tick();

      // spurious B/R while idle are ignored
      spur = 1; viol = 0;
      repeat (3) begin
         tick();
         if (o_bready || o_rready || o_rsp_valid || !o_cmd_ready) viol++;
      end
      spur = 0;
      tick();
      check("spurious_ignored", viol, 0);

      // directed cases
      do_txn(1, 32'h10, 32'hA5A5_0001, 4'hF, 0, 0, 0, 0, 0, 0, 0);
      do_txn(0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 4, 2, 0, 0);
      check("read_back", o_rsp_data, 32'hA5A5_0001);
      do_txn(1, 32'h14, 32'h1234_5678, 4'h5, 4, 0, 0, 0, 0, 0, 0);
      do_txn(0, 32'h14, 32'h0, 4'h0, 0, 0, 0, 1, 1, 3, 0);
      do_txn(1, 32'h18, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0, 0, 3, 0);
      do_txn(0, 32'hFFFF_FFFC, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
      do_txn(1, 32'hE000_0008, 32'h1, 4'hF, 1, 2, 1, 0, 0, 0, 0);

      // reset in the middle of a stalled write
      aw_wait = 20; w_wait = 20; aw_got = 0; w_got = 0; b_done = 0; r_done = 1;
      i_cmd_valid = 1; i_cmd_wr = 1; i_cmd_addr = 32'h20; i_cmd_data = 32'h5555_AAAA; i_cmd_strb = 4'hF;
      tick();
      i_cmd_valid = 0;
      tick(); tick();
      check("mid_wr_awvalid", o_awvalid, 1);
      rst = 1;
      tick();
      rst = 0;
      check("post_rst_valids", {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready}, 0);
      check("post_rst_cmd_ready", o_cmd_ready, 1);
      rsp_seen = 0;
      repeat (5) begin
         if (o_rsp_valid) rsp_seen++;
         tick();
      end
      check("post_rst_no_rsp", rsp_seen, 0);
      do_txn(0, 32'h20, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0);

`ifdef AXIML_TIMEOUT_EN
      do_txn(0, 32'h24, 32'h0, 4'h0, 0, 0, 0, 1000, 0, 1, 1);
      check("arvalid_after_to", o_arvalid, 0);
`endif

      // randomized traffic
      for (int t = 0; t < 40; t++) begin
         logic [31:0] a;
         int          sel;
         sel = int'($urandom_range(0, 7));
         a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
         if (sel == 6) a[31:28] = 4'hF;
         if (sel == 7) a[31:28] = 4'hE;
         do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_time_limit: got=expired expected=finish");
      $fatal(1, "time limit");
   end
endmodule
